sram_test_sequencer: RTL and testbench
======================================

SRAM_TEST_SEQUENCER -- requirements
Module: sram_test_sequencer

Interface
REQ-001 SHALL have parameter pCNT_WIDTH, default 32: width of the run-length timer and I_run_len.
REQ-002 SHALL have parameter pGAP_CYCLES, default 4: cycles O_active is held low between iterations (min 2).
REQ-003 SHALL have parameter pLED_DIV, default 24: heartbeat divider width.
REQ-004 SHALL have port clk  input  1  the single clock for all logic.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port I_start  input  1  start pulse, level-sampled each clk.
REQ-007 SHALL have port I_abort  input  1  abort request, level-sampled.
REQ-008 SHALL have port I_run_len  input  pCNT_WIDTH  cycles per iteration with O_active high; latched on start.
REQ-009 SHALL have port I_iterations  input  8  iterations to run; 0 = run until abort; latched on start.
REQ-010 SHALL have port I_pass  input  1  pass from the SRAM R/W tester.
REQ-011 SHALL have port I_fail  input  1  fail from the SRAM R/W tester.
REQ-012 SHALL have port O_active  output  1  enable to the SRAM R/W tester.
REQ-013 SHALL have ports O_busy, O_done, O_aborted  output  1 each  status flags.
REQ-014 SHALL have ports O_iter_count, O_fail_count  output  8 each  completed / failed iterations.
REQ-015 SHALL have port O_led  output  1  status LED.

Function
REQ-016 SHALL implement states IDLE, RUN, GAP, DONE; O_busy high exactly in RUN and GAP.
REQ-017 IDLE/DONE: I_start high and I_abort low -> latch I_run_len, I_iterations; clear counters, O_done, O_aborted, fail flag; go RUN; O_active high from the next cycle.
REQ-018 I_start while in RUN or GAP SHALL be ignored.
REQ-019 RUN: O_active high for exactly max(I_run_len,1) cycles; I_run_len=0 treated as 1.
REQ-020 RUN: I_fail high in any cycle sets a sticky per-iteration fail flag.
REQ-021 RUN end (last RUN cycle's edge): iteration fails if fail flag set or I_pass low in that cycle; O_iter_count +1; O_fail_count +1 on failure; go GAP.
REQ-022 O_iter_count and O_fail_count SHALL saturate at 255, never wrap.
REQ-023 GAP: O_active low for exactly pGAP_CYCLES cycles; fail flag cleared on entry.
REQ-024 GAP end: go DONE if latched iterations non-zero and O_iter_count equals it, else RUN.
REQ-025 With latched iterations 0, iterating SHALL continue past O_iter_count=255 (count held at 255).
REQ-026 DONE: O_done high, O_active low, counters held until next start.
REQ-027 I_abort high in RUN or GAP -> O_active low next cycle, go IDLE, O_aborted high, counters held, partial iteration not counted.
REQ-028 I_start and I_abort high together SHALL be treated as abort only (no start).
REQ-029 O_led: IDLE 0; busy = MSB of free-running pLED_DIV-bit counter; DONE with O_fail_count=0 solid 1; DONE with failures = bit pLED_DIV-3 (fast blink).
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 reset_n low SHALL asynchronously force IDLE, O_active 0, O_busy 0, O_done 0, O_aborted 0, both counters 0, fail flag 0, LED counter 0, O_led 0.
REQ-032 Reset assertion mid-RUN SHALL drop O_active immediately without waiting for clk.
REQ-033 After reset_n deasserts, no iteration SHALL start without a fresh I_start.

Verification
REQ-034 I_run_len=10, I_iterations=3, I_pass=1, I_fail=0, pGAP_CYCLES=4 -> O_active 10 high/4 low x3; O_done; iter 3, fail 0; O_led 1.
REQ-035 Same, I_fail pulsed one cycle in iteration 2 only -> iter 3, fail 1; O_led fast-blinks in DONE.
REQ-036 I_iterations=0, I_run_len=1, 300 iterations, I_pass=0 -> both counters stop at 255; still busy; I_abort -> IDLE, O_aborted 1.
REQ-037 I_abort at RUN cycle 5 of 10 -> O_active low next cycle, iter count unchanged, O_done 0.
REQ-038 I_start+I_abort same cycle in IDLE -> O_active stays 0, O_aborted 1; I_run_len=0 start -> one-cycle O_active pulses.
REQ-039 reset_n low between clk edges during RUN -> O_active and counters 0 before next edge; no restart after release.

Source files
------------

// File: rtl/sram_test_sequencer.sv
// Sequences repeated enable windows to an SRAM read/write tester, tallies
// pass/fail per iteration and drives a status LED.
module sram_test_sequencer #(
  parameter int unsigned pCNT_WIDTH  = 32,
  parameter int unsigned pGAP_CYCLES = 4,
  parameter int unsigned pLED_DIV    = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  I_start,
  input  logic                  I_abort,
  input  logic [pCNT_WIDTH-1:0] I_run_len,
  input  logic [7:0]            I_iterations,
  input  logic                  I_pass,
  input  logic                  I_fail,
  output logic                  O_active,
  output logic                  O_busy,
  output logic                  O_done,
  output logic                  O_aborted,
  output logic [7:0]            O_iter_count,
  output logic [7:0]            O_fail_count,
  output logic                  O_led
);

  localparam int unsigned lpGAP_W = $clog2(pGAP_CYCLES);
  localparam logic [lpGAP_W-1:0] lpGAP_LAST = lpGAP_W'(pGAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GAP,
    DONE
  } state_t;

  state_t                r_state;
  logic [pCNT_WIDTH-1:0] r_run_len;
  logic [pCNT_WIDTH-1:0] r_run_cnt;
  logic [lpGAP_W-1:0]    r_gap_cnt;
  logic [7:0]            r_iter_lat;
  logic                  r_fail_flag;
  logic [pLED_DIV-1:0]   r_led_cnt;

  logic [pCNT_WIDTH-1:0] w_run_reload;
  logic                  w_iter_fail;
  logic [7:0]            w_iter_next;
  logic [7:0]            w_fail_next;
  logic                  w_last_iter;

  // Run counter holds remaining cycles after the current one, so a zero length behaves as one.
  assign w_run_reload = (I_run_len == '0) ? '0 : I_run_len - pCNT_WIDTH'(1);
  assign w_iter_fail  = r_fail_flag | I_fail | ~I_pass;
  assign w_iter_next  = (O_iter_count == 8'hFF) ? O_iter_count : O_iter_count + 8'd1;
  assign w_fail_next  = (O_fail_count == 8'hFF) ? O_fail_count : O_fail_count + 8'd1;
  assign w_last_iter  = (r_iter_lat != 8'd0) && (O_iter_count == r_iter_lat);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_run_len    <= '0;
      r_run_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_iter_lat   <= '0;
      r_fail_flag  <= 1'b0;
      O_active     <= 1'b0;
      O_busy       <= 1'b0;
      O_done       <= 1'b0;
      O_aborted    <= 1'b0;
      O_iter_count <= '0;
      O_fail_count <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (I_start && I_abort) begin
            r_state   <= IDLE;
            O_done    <= 1'b0;
            O_aborted <= 1'b1;
          end else if (I_start) begin
            r_state      <= RUN;
            r_run_len    <= w_run_reload;
            r_run_cnt    <= w_run_reload;
            r_iter_lat   <= I_iterations;
            r_fail_flag  <= 1'b0;
            O_iter_count <= '0;
            O_fail_count <= '0;
            O_done       <= 1'b0;
            O_aborted    <= 1'b0;
            O_active     <= 1'b1;
            O_busy       <= 1'b1;
          end
        end

        RUN: begin
          if (I_abort) begin
            r_state     <= IDLE;
            r_fail_flag <= 1'b0;
            O_active    <= 1'b0;
            O_busy      <= 1'b0;
            O_aborted   <= 1'b1;
          end else if (r_run_cnt == '0) begin
            O_iter_count <= w_iter_next;
            if (w_iter_fail) begin
              O_fail_count <= w_fail_next;
            end
            r_fail_flag <= 1'b0;
            r_gap_cnt   <= lpGAP_LAST;
            O_active    <= 1'b0;
            r_state     <= GAP;
          end else begin
            r_run_cnt <= r_run_cnt - pCNT_WIDTH'(1);
            if (I_fail) begin
              r_fail_flag <= 1'b1;
            end
          end
        end

        GAP: begin
          if (I_abort) begin
            r_state     <= IDLE;
            r_fail_flag <= 1'b0;
            O_active    <= 1'b0;
            O_busy      <= 1'b0;
            O_aborted   <= 1'b1;
          end else if (r_gap_cnt == '0) begin
            if (w_last_iter) begin
              r_state <= DONE;
              O_busy  <= 1'b0;
              O_done  <= 1'b1;
            end else begin
              r_state   <= RUN;
              r_run_cnt <= r_run_len;
              O_active  <= 1'b1;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt - lpGAP_W'(1);
          end
        end

        default: begin
          r_state  <= IDLE;
          O_active <= 1'b0;
          O_busy   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_led_cnt <= '0;
      O_led     <= 1'b0;
    end else begin
      r_led_cnt <= r_led_cnt + pLED_DIV'(1);
      case (r_state)
        RUN, GAP: O_led <= r_led_cnt[pLED_DIV-1];
        DONE:     O_led <= (O_fail_count == 8'd0) ? 1'b1 : r_led_cnt[pLED_DIV-3];
        default:  O_led <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_test_sequencer.sv
// Directed bench for sram_test_sequencer; inputs change and outputs are sampled on clk negedges.
module tb_sram_test_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        I_start = 1'b0;
  logic        I_abort = 1'b0;
  logic [31:0] I_run_len = '0;
  logic [7:0]  I_iterations = '0;
  logic        I_pass = 1'b1;
  logic        I_fail = 1'b0;
  logic        O_active;
  logic        O_busy;
  logic        O_done;
  logic        O_aborted;
  logic [7:0]  O_iter_count;
  logic [7:0]  O_fail_count;
  logic        O_led;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  sram_test_sequencer #(
    .pCNT_WIDTH (32),
    .pGAP_CYCLES(4),
    .pLED_DIV   (6)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .I_start     (I_start),
    .I_abort     (I_abort),
    .I_run_len   (I_run_len),
    .I_iterations(I_iterations),
    .I_pass      (I_pass),
    .I_fail      (I_fail),
    .O_active    (O_active),
    .O_busy      (O_busy),
    .O_done      (O_done),
    .O_aborted   (O_aborted),
    .O_iter_count(O_iter_count),
    .O_fail_count(O_fail_count),
    .O_led       (O_led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called on a negedge; the start is taken on the following posedge.
  task automatic do_start(input logic [31:0] len, input logic [7:0] iters);
    I_run_len    = len;
    I_iterations = iters;
    I_start      = 1'b1;
    @(negedge clk);
    I_start = 1'b0;
  endtask

  // Samples O_active each negedge until O_done, checking every high and low run length.
  task automatic run_iters(input int unsigned exp_len, input int unsigned exp_gap,
                           input int unsigned fail_iter, input int unsigned start_iter,
                           input int unsigned max_cyc, output int unsigned nruns);
    int unsigned len  = 0;
    int unsigned gap  = 0;
    int unsigned runs = 0;
    bit          prev = 1'b0;
    bit          done = 1'b0;
    for (int unsigned c = 0; c < max_cyc && !done; c++) begin
      I_fail  = 1'b0;
      I_start = 1'b0;
      if (O_active) begin
        if (!prev) begin
          if (runs > 0) check("gap_len", gap, exp_gap);
          runs++;
          len = 0;
        end
        len++;
        if (runs == fail_iter && len == 3) I_fail = 1'b1;
        if (runs == start_iter && len == 5) I_start = 1'b1;
      end else begin
        if (prev) begin
          check("run_len", len, exp_len);
          gap = 0;
        end
        gap++;
      end
      prev = O_active;
      if (O_done) done = 1'b1;
      else @(negedge clk);
    end
    I_fail  = 1'b0;
    I_start = 1'b0;
    check("done_reached", done, 1);
    nruns = runs;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned nruns;
    int unsigned highs;
    int unsigned rises;
    int unsigned ones;
    bit          prev;

    repeat (3) @(negedge clk);
    check("rst_active", O_active, 0);
    check("rst_busy", O_busy, 0);
    check("rst_done", O_done, 0);
    check("rst_aborted", O_aborted, 0);
    check("rst_iter", O_iter_count, 0);
    check("rst_fail", O_fail_count, 0);
    check("rst_led", O_led, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_active", O_active, 0);

    // Start and abort together: abort wins, nothing starts.
    I_run_len = 32'd10; I_iterations = 8'd3;
    I_start = 1'b1; I_abort = 1'b1;
    @(negedge clk);
    I_start = 1'b0; I_abort = 1'b0;
    check("sa_aborted", O_aborted, 1);
    check("sa_active", O_active, 0);
    check("sa_busy", O_busy, 0);
    repeat (3) @(negedge clk);
    check("sa_active_hold", O_active, 0);

    // Three clean iterations; a start pulse inside the first run is ignored.
    I_pass = 1'b1;
    do_start(32'd10, 8'd3);
    check("t1_abort_clr", O_aborted, 0);
    check("t1_busy", O_busy, 1);
    run_iters(10, 4, 0, 1, 100, nruns);
    check("t1_runs", nruns, 3);
    check("t1_iter", O_iter_count, 3);
    check("t1_fail", O_fail_count, 0);
    check("t1_busy_done", O_busy, 0);
    check("t1_active_done", O_active, 0);
    repeat (2) @(negedge clk);
    check("t1_led", O_led, 1);
    check("t1_done_hold", O_done, 1);

    // One-cycle fail pulse in iteration 2 only.
    do_start(32'd10, 8'd3);
    check("t2_done_clr", O_done, 0);
    check("t2_iter_clr", O_iter_count, 0);
    run_iters(10, 4, 2, 0, 100, nruns);
    check("t2_runs", nruns, 3);
    check("t2_iter", O_iter_count, 3);
    check("t2_fail", O_fail_count, 1);
    ones = 0;
    repeat (32) begin
      @(negedge clk);
      ones += O_led;
    end
    check("t2_led_ones", ones, 16);

    // Abort at cycle 5 of iteration 2.
    do_start(32'd10, 8'd3);
    repeat (18) @(negedge clk);
    check("t4_active_pre", O_active, 1);
    check("t4_iter_pre", O_iter_count, 1);
    I_abort = 1'b1;
    @(negedge clk);
    I_abort = 1'b0;
    check("t4_active", O_active, 0);
    check("t4_iter", O_iter_count, 1);
    check("t4_done", O_done, 0);
    check("t4_aborted", O_aborted, 1);
    check("t4_busy", O_busy, 0);
    repeat (20) @(negedge clk);
    check("t4_stay_idle", O_active, 0);

    // Zero run length behaves as one.
    do_start(32'd0, 8'd2);
    run_iters(1, 4, 0, 0, 50, nruns);
    check("t5_runs", nruns, 2);
    check("t5_iter", O_iter_count, 2);

    // Endless mode with I_pass low: both counters saturate, iterating continues.
    I_pass = 1'b0;
    do_start(32'd1, 8'd0);
    highs = 0; rises = 0; prev = 1'b0;
    repeat (1600) begin
      highs += O_active;
      if (O_active && !prev) rises++;
      prev = O_active;
      @(negedge clk);
    end
    check("t3_pulse_width", highs, rises);
    check("t3_past_255", rises >= 300, 1);
    check("t3_iter", O_iter_count, 255);
    check("t3_fail", O_fail_count, 255);
    check("t3_busy", O_busy, 1);
    check("t3_done", O_done, 0);
    I_abort = 1'b1;
    @(negedge clk);
    I_abort = 1'b0;
    check("t3_aborted", O_aborted, 1);
    check("t3_busy_abort", O_busy, 0);
    check("t3_iter_held", O_iter_count, 255);
    I_pass = 1'b1;

    // Asynchronous reset mid-run in iteration 2.
    do_start(32'd10, 8'd3);
    repeat (15) @(negedge clk);
    check("t6_iter_pre", O_iter_count, 1);
    check("t6_active_pre", O_active, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_active", O_active, 0);
    check("t6_iter", O_iter_count, 0);
    check("t6_busy", O_busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    highs = 0;
    repeat (30) begin
      @(negedge clk);
      highs += O_active;
    end
    check("t6_no_restart", highs, 0);
    check("t6_busy_after", O_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
